// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis constants, state type and expected-symbol helper
package viterbi_pkg;
  localparam int K = 3;
  localparam int NUM_STATES = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;
  typedef logic [1:0] state_t;
  function automatic logic [1:0] exp_sym(input logic b, input state_t s);
    logic [2:0] sr;
    sr = {b, s};
    return {^(sr & G0), ^(sr & G1)};
  endfunction
endpackage

// File: rtl/viterbi_bmu.sv
// viterbi_bmu: hard-decision branch metrics of sym against all four expected symbols
module viterbi_bmu
  import viterbi_pkg::*;
(
  input  logic [1:0]      sym,
  output logic [3:0][1:0] bm
);
  for (genvar e = 0; e < NUM_STATES; e++) begin : g_bm
    localparam logic [1:0] E = 2'(e);
    assign bm[e] = {1'b0, sym[1] ^ E[1]} + {1'b0, sym[0] ^ E[0]};
  end
endmodule

// File: rtl/viterbi_acs.sv
// viterbi_acs: add-compare-select with MSB normalisation, argmin and registered decisions
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = 6,
  parameter int INIT_PM = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  input  logic            start_i,
  input  logic            valid_i,
  input  logic [1:0]      sym_i,
  output logic            valid_o,
  output logic [3:0]      dec_o,
  output logic [1:0]      best_state_o,
  output logic [PM_W-1:0] best_pm_o
);
  logic [3:0][PM_W-1:0] pm, base, c0, c1, pm_r, pm_n;
  logic [3:0][1:0] bm;
  logic [3:0] dec;
  logic [1:0] bs;
  logic [PM_W-1:0] bpm;
  logic norm, upd;
  assign upd = enable_i & valid_i;
  viterbi_bmu u_bmu (.sym(sym_i), .bm(bm));
  // ACS over the trellis (start_i swaps in the initial metrics), then normalise and pick the minimum
  always_comb begin
    base = pm;
    c0 = '0;
    c1 = '0;
    pm_r = '0;
    pm_n = '0;
    dec = '0;
    norm = 1'b1;
    bs = '0;
    for (int n = 0; n < NUM_STATES; n++) begin
      base[n] = start_i ? ((n == 0) ? '0 : PM_W'(INIT_PM)) : pm[n];
    end
    for (int n = 0; n < NUM_STATES; n++) begin
      c0[n] = base[{n[0], 1'b0}] + PM_W'(bm[exp_sym(n[1], state_t'({n[0], 1'b0}))]);
      c1[n] = base[{n[0], 1'b1}] + PM_W'(bm[exp_sym(n[1], state_t'({n[0], 1'b1}))]);
      dec[n] = c1[n] < c0[n];
      pm_r[n] = dec[n] ? c1[n] : c0[n];
      norm = norm & pm_r[n][PM_W-1];
    end
    for (int n = 0; n < NUM_STATES; n++) begin
      pm_n[n] = {pm_r[n][PM_W-1] & ~norm, pm_r[n][PM_W-2:0]};
    end
    bpm = pm_n[0];
    for (int n = 1; n < NUM_STATES; n++) begin
      bs = (pm_n[n] < bpm) ? 2'(n) : bs;
      bpm = (pm_n[n] < bpm) ? pm_n[n] : bpm;
    end
  end
  // metric store and output registers; a start without a symbol only reloads the metrics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_STATES; n++) pm[n] <= (n == 0) ? '0 : PM_W'(INIT_PM);
      valid_o <= 1'b0;
      dec_o <= '0;
      best_state_o <= '0;
      best_pm_o <= '0;
    end else begin
      valid_o <= upd;
      if (upd) begin
        pm <= pm_n;
        dec_o <= dec;
        best_state_o <= bs;
        best_pm_o <= bpm;
      end else if (start_i) begin
        pm <= base;
      end
    end
  end
endmodule

// File: tb/tb_viterbi_acs.sv
// tb_viterbi_acs: directed and random checks of viterbi_acs against a forward trellis model
module tb_viterbi_acs;
  localparam int PMW = 6;
  localparam int INIT = 8;
  logic clk = 1'b0;
  logic rst, enable_i, start_i, valid_i;
  logic [1:0] sym_i;
  logic valid_o;
  logic [3:0] dec_o;
  logic [1:0] best_state_o;
  logic [PMW-1:0] best_pm_o;
  int n_chk = 0;
  int errs = 0;
  int pm_m[4];
  int m_valid, m_dec, m_bs, m_bpm;
  logic [1:0] clean[12] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3};
  int exp_bs[12] = '{0, 2, 1, 0, 0, 2, 1, 0, 2, 3, 1, 0};

  viterbi_acs #(.PM_W(PMW), .INIT_PM(INIT)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .start_i(start_i), .valid_i(valid_i),
    .sym_i(sym_i), .valid_o(valid_o), .dec_o(dec_o), .best_state_o(best_state_o),
    .best_pm_o(best_pm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pm_m = '{0, INIT, INIT, INIT};
    m_valid = 0; m_dec = 0; m_bs = 0; m_bpm = 0;
  endtask

  // forward relaxation: every (state, input) edge offers a candidate to its successor
  task automatic model(input logic [1:0] s, input logic v, input logic e, input logic st);
    int base[4], best[4], ds[4], ns, bm, c, all_hi;
    for (int i = 0; i < 4; i++) base[i] = st ? ((i == 0) ? 0 : INIT) : pm_m[i];
    if (v && e) begin
      for (int i = 0; i < 4; i++) begin best[i] = 1000; ds[i] = 0; end
      for (int p = 0; p < 4; p++)
        for (int b = 0; b < 2; b++) begin
          ns = b * 2 + p / 2;
          bm = int'(int'(s[1]) != (b ^ (p / 2) ^ (p % 2))) + int'(int'(s[0]) != (b ^ (p % 2)));
          c = base[p] + bm;
          if (c < best[ns]) begin best[ns] = c; ds[ns] = p % 2; end
        end
      all_hi = 1;
      for (int i = 0; i < 4; i++) if (best[i] < 32) all_hi = 0;
      if (all_hi == 1) for (int i = 0; i < 4; i++) best[i] -= 32;
      m_dec = 0; m_bs = 0;
      for (int i = 0; i < 4; i++) begin
        pm_m[i] = best[i];
        m_dec += ds[i] << i;
        if (best[i] < best[m_bs]) m_bs = i;
      end
      m_bpm = best[m_bs];
      m_valid = 1;
    end else begin
      if (st) pm_m = '{0, INIT, INIT, INIT};
      m_valid = 0;
    end
  endtask

  task automatic step(input string tag, input logic [1:0] s, input logic v, input logic e,
                      input logic st);
    @(negedge clk);
    sym_i = s; valid_i = v; enable_i = e; start_i = st;
    model(s, v, e, st);
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, int'(valid_o), m_valid);
    chk({tag, ".dec"}, int'(dec_o), m_dec);
    chk({tag, ".state"}, int'(best_state_o), m_bs);
    chk({tag, ".pm"}, int'(best_pm_o), m_bpm);
  endtask

  initial begin
    logic [1:0] s;
    rst = 1'b0; enable_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; sym_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", int'(valid_o), 0);
    chk("reset.dec", int'(dec_o), 0);
    chk("reset.state", int'(best_state_o), 0);
    chk("reset.pm", int'(best_pm_o), 0);
    @(negedge clk);
    rst = 1'b1;
    // clean stream
    for (int i = 0; i < 12; i++) begin
      step("clean", clean[i], 1'b1, 1'b1, 1'b0);
      chk("clean.spec_state", int'(best_state_o), exp_bs[i]);
      chk("clean.spec_pm", int'(best_pm_o), 0);
    end
    // single error on symbol 3, new frame via start
    for (int i = 0; i < 12; i++) begin
      s = (i == 3) ? 2'b01 : clean[i];
      step("err", s, 1'b1, 1'b1, 1'(i == 0));
      chk("err.spec_pm", int'(best_pm_o), (i < 3) ? 0 : 1);
    end
    chk("err.final_state", int'(best_state_o), 0);
    // gating mid-stream, X on sym while invalid
    for (int i = 0; i < 12; i++) begin
      if (i == 6) begin
        step("gate_v", 2'bxx, 1'b0, 1'b1, 1'b0);
        step("gate_v", 2'bxx, 1'b0, 1'b1, 1'b0);
        step("gate_e", 2'b01, 1'b1, 1'b0, 1'b0);
        step("gate_e", 2'b10, 1'b1, 1'b0, 1'b0);
        chk("gate.hold_state", int'(best_state_o), exp_bs[5]);
      end
      step("gate", clean[i], 1'b1, 1'b1, 1'(i == 0));
      chk("gate.spec_state", int'(best_state_o), exp_bs[i]);
    end
    // restart mid-frame with a symbol
    step("pre", 2'b10, 1'b1, 1'b1, 1'b0);
    step("pre", 2'b01, 1'b1, 1'b1, 1'b0);
    step("restart", 2'b11, 1'b1, 1'b1, 1'b1);
    chk("restart.spec_state", int'(best_state_o), 2);
    chk("restart.spec_pm", int'(best_pm_o), 0);
    // start without symbol, and with enable low
    step("reload", 2'b00, 1'b0, 1'b1, 1'b1);
    step("after_reload", 2'b00, 1'b1, 1'b1, 1'b0);
    step("pre2", 2'b11, 1'b1, 1'b1, 1'b0);
    step("reload_en0", 2'b11, 1'b1, 1'b0, 1'b1);
    step("after_reload2", 2'b11, 1'b1, 1'b1, 1'b0);
    // async reset mid-frame
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("areset.valid", int'(valid_o), 0);
    chk("areset.dec", int'(dec_o), 0);
    chk("areset.state", int'(best_state_o), 0);
    chk("areset.pm", int'(best_pm_o), 0);
    @(negedge clk);
    rst = 1'b1;
    // all-error stream drives metrics through normalisation
    for (int i = 0; i < 40; i++) begin
      step("norm", 2'b11, 1'b1, 1'b1, 1'(i == 0));
      chk("norm.bound", int'(best_pm_o < 6'd32), 1);
    end
    // random traffic
    for (int i = 0; i < 300; i++) begin
      step("rand", 2'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           1'($urandom_range(0, 29) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errs);
    $finish;
  end
endmodule
